// File: rtl/vx_dp_ram_pkg.sv
// Shared helpers for the vx_dp_ram simple dual-port memory.
package vx_dp_ram_pkg;

  localparam int LANE_W = 8;

  // Address width that stays at least one bit wide for single-word memories.
  function automatic int addr_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/vx_dp_ram.sv
// Simple dual-port RAM: one write port, one read port, one clock.
// FASTRAM selects an asynchronous (LUTRAM) or registered (block RAM) read.
module vx_dp_ram
  import vx_dp_ram_pkg::*;
#(
  parameter int DATAW   = 1,
  parameter int SIZE    = 1,
  parameter int BYTEENW = 1,
  parameter bit FASTRAM = 0,
  localparam int ADDRW  = addr_width(SIZE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDRW-1:0]   waddr,
  input  logic [ADDRW-1:0]   raddr,
  input  logic               wren,
  input  logic [BYTEENW-1:0] byteen,
  input  logic               rden,
  input  logic [DATAW-1:0]   din,
  output logic [DATAW-1:0]   dout
);

  // A 1-bit address needs two rows to index cleanly; row 1 is never written.
  localparam int DEPTH = (SIZE > 1) ? SIZE : 2;

  if (SIZE < 1) begin : g_bad_size
    $error("vx_dp_ram: SIZE must be at least 1");
  end
  if (BYTEENW > 1 && DATAW != BYTEENW * LANE_W) begin : g_bad_lanes
    $error("vx_dp_ram: DATAW must equal BYTEENW*8 when BYTEENW > 1");
  end

  logic [DATAW-1:0] wmask;
  logic             wr_ok;

  if (BYTEENW > 1) begin : g_lanes
    for (genvar i = 0; i < BYTEENW; i++) begin : g_lane
      assign wmask[i*LANE_W +: LANE_W] = {LANE_W{byteen[i]}};
    end
  end else begin : g_word
    assign wmask = {DATAW{byteen[0]}};
  end

  // Out-of-range writes are dropped rather than aliased onto a legal row.
  assign wr_ok = wren && (int'(waddr) < SIZE);

  if (FASTRAM) begin : g_fast
    (* ram_style = "distributed" *) logic [DATAW-1:0] mem [DEPTH];
    logic unused_fast;

    // NOTE: the array has no reset; clearing it would block RAM inference.
    always_ff @(posedge clk) begin
      if (wr_ok) begin
        mem[waddr] <= (mem[waddr] & ~wmask) | (din & wmask);
      end
    end

    assign dout        = mem[raddr];
    assign unused_fast = &{1'b0, rden, reset};
  end else begin : g_block
    (* ram_style = "block" *) logic [DATAW-1:0] mem [DEPTH];
    logic [DATAW-1:0] rdata;

    always_ff @(posedge clk) begin
      if (wr_ok) begin
        mem[waddr] <= (mem[waddr] & ~wmask) | (din & wmask);
      end
    end

    always_ff @(posedge clk) begin
      // NOTE: non-blocking updates make rdata sample mem before this edge's write (read-first).
      if (reset) begin
        rdata <= '0;
      end else if (rden) begin
        rdata <= mem[raddr];
      end
    end

    assign dout = rdata;
  end

  always_ff @(posedge clk) begin
    if (wren && !$isunknown(waddr)) begin
      assert (int'(waddr) < SIZE);
    end
    if ((FASTRAM || rden) && !$isunknown(raddr)) begin
      assert (int'(raddr) < SIZE);
    end
  end

endmodule

// File: tb/tb_vx_dp_ram.sv
// Self-checking bench: a fast-read 36-bit instance and a registered-read byte-lane instance.
module tb_vx_dp_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [1:0]  f_waddr, f_raddr;
  logic        f_wren, f_rden;
  logic [0:0]  f_byteen;
  logic [35:0] f_din, f_dout;

  logic [2:0]  r_waddr, r_raddr;
  logic        r_wren, r_rden;
  logic [3:0]  r_byteen;
  logic [31:0] r_din, r_dout;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference contents, only trusted once every row has been fully written.
  logic [35:0] ref_f [4];
  logic [31:0] ref_r [8];

  vx_dp_ram #(.DATAW(36), .SIZE(4), .BYTEENW(1), .FASTRAM(1)) u_fast (
    .clk(clk), .reset(reset), .waddr(f_waddr), .raddr(f_raddr), .wren(f_wren),
    .byteen(f_byteen), .rden(f_rden), .din(f_din), .dout(f_dout)
  );

  vx_dp_ram #(.DATAW(32), .SIZE(8), .BYTEENW(4), .FASTRAM(0)) u_reg (
    .clk(clk), .reset(reset), .waddr(r_waddr), .raddr(r_raddr), .wren(r_wren),
    .byteen(r_byteen), .rden(r_rden), .din(r_din), .dout(r_dout)
  );

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  en);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (en[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    r_rden  = 1'b1;
    r_raddr = 3'd0;
    tick();
    n_cmp++;
    if (r_dout !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_clear: got %h want %h", r_dout, 32'h0);
    end
    tick();
    n_cmp++;
    if (r_dout !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_over_rden: got %h want %h", r_dout, 32'h0);
    end
    reset  = 1'b0;
    r_rden = 1'b0;
  endtask

  task automatic test_fast_read();
    f_wren = 1'b1; f_byteen = 1'b1; f_waddr = 2'd2; f_din = 36'h9_DEADBEEF;
    tick();
    f_wren  = 1'b0;
    f_raddr = 2'd2;
    #1;
    n_cmp++;
    if (f_dout !== 36'h9_DEADBEEF) begin
      n_bad++;
      $display("FAIL fast_read_a2: got %h want %h", f_dout, 36'h9_DEADBEEF);
    end
    f_wren = 1'b1; f_waddr = 2'd3; f_din = 36'h1_00000004;
    tick();
    f_wren  = 1'b0;
    f_raddr = 2'd3;
    #1;
    n_cmp++;
    if (f_dout !== 36'h1_00000004) begin
      n_bad++;
      $display("FAIL fast_read_a3: got %h want %h", f_dout, 36'h1_00000004);
    end
    f_raddr = 2'd2;
    #1;
    n_cmp++;
    if (f_dout !== 36'h9_DEADBEEF) begin
      n_bad++;
      $display("FAIL fast_read_back_a2: got %h want %h", f_dout, 36'h9_DEADBEEF);
    end
  endtask

  task automatic test_fast_rdw();
    f_wren = 1'b1; f_byteen = 1'b1; f_waddr = 2'd1; f_din = 36'hA;
    tick();
    f_raddr = 2'd1; f_din = 36'hB; f_rden = 1'b0;
    #1;
    n_cmp++;
    if (f_dout !== 36'hA) begin
      n_bad++;
      $display("FAIL fast_rdw_before: got %h want %h", f_dout, 36'hA);
    end
    tick();
    f_wren = 1'b0;
    #1;
    n_cmp++;
    if (f_dout !== 36'hB) begin
      n_bad++;
      $display("FAIL fast_rdw_after: got %h want %h", f_dout, 36'hB);
    end
  endtask

  task automatic test_fast_byteen0();
    f_wren = 1'b1; f_byteen = 1'b1; f_waddr = 2'd0; f_din = 36'h5_A5A5A5A5;
    tick();
    f_byteen = 1'b0; f_din = 36'h0_12345678;
    tick();
    f_wren = 1'b0; f_raddr = 2'd0;
    #1;
    n_cmp++;
    if (f_dout !== 36'h5_A5A5A5A5) begin
      n_bad++;
      $display("FAIL fast_byteen0: got %h want %h", f_dout, 36'h5_A5A5A5A5);
    end
  endtask

  task automatic test_reg_byteen();
    r_wren = 1'b1; r_waddr = 3'd5; r_byteen = 4'hF; r_din = 32'h11223344;
    tick();
    r_byteen = 4'b0101; r_din = 32'hAABBCCDD;
    tick();
    r_wren = 1'b0; r_rden = 1'b1; r_raddr = 3'd5;
    tick();
    r_rden = 1'b0;
    n_cmp++;
    if (r_dout !== 32'h11BB33DD) begin
      n_bad++;
      $display("FAIL reg_byteen_merge: got %h want %h", r_dout, 32'h11BB33DD);
    end
  endtask

  task automatic test_reg_hold();
    r_rden = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r_raddr = 3'(i);
      tick();
      n_cmp++;
      if (r_dout !== 32'h11BB33DD) begin
        n_bad++;
        $display("FAIL reg_hold_%0d: got %h want %h", i, r_dout, 32'h11BB33DD);
      end
    end
    r_wren = 1'b1; r_waddr = 3'd5; r_byteen = 4'hF; r_din = 32'hCAFEF00D;
    r_rden = 1'b1; r_raddr = 3'd5;
    tick();
    r_wren = 1'b0;
    n_cmp++;
    if (r_dout !== 32'h11BB33DD) begin
      n_bad++;
      $display("FAIL reg_read_first: got %h want %h", r_dout, 32'h11BB33DD);
    end
    tick();
    r_rden = 1'b0;
    n_cmp++;
    if (r_dout !== 32'hCAFEF00D) begin
      n_bad++;
      $display("FAIL reg_read_new: got %h want %h", r_dout, 32'hCAFEF00D);
    end
  endtask

  task automatic test_reg_reset();
    reset = 1'b1; r_rden = 1'b1; r_raddr = 3'd5;
    tick();
    n_cmp++;
    if (r_dout !== 32'h0) begin
      n_bad++;
      $display("FAIL reg_reset_mid: got %h want %h", r_dout, 32'h0);
    end
    reset = 1'b0;
    tick();
    r_rden = 1'b0;
    n_cmp++;
    if (r_dout !== 32'hCAFEF00D) begin
      n_bad++;
      $display("FAIL reg_contents_kept: got %h want %h", r_dout, 32'hCAFEF00D);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_r;
    // Fill every row so the model is fully defined.
    f_wren = 1'b1; f_byteen = 1'b1; r_wren = 1'b1; r_byteen = 4'hF;
    f_rden = 1'b0; r_rden = 1'b0;
    for (int a = 0; a < 8; a++) begin
      r_waddr = 3'(a);
      r_din   = $urandom;
      ref_r[a] = r_din;
      f_waddr = 2'(a % 4);
      f_din   = {4'($urandom_range(0, 15)), $urandom};
      ref_f[a % 4] = f_din;
      tick();
    end
    f_wren = 1'b0; r_wren = 1'b0;
    reset  = 1'b1;
    tick();
    reset  = 1'b0;
    exp_r  = 32'h0;

    for (int n = 0; n < 300; n++) begin
      f_wren   = 1'($urandom_range(0, 1));
      f_byteen = 1'($urandom_range(0, 1));
      f_rden   = 1'($urandom_range(0, 1));
      f_waddr  = 2'($urandom_range(0, 3));
      f_raddr  = 2'($urandom_range(0, 3));
      f_din    = {4'($urandom_range(0, 15)), $urandom};
      r_wren   = 1'($urandom_range(0, 1));
      r_byteen = 4'($urandom_range(0, 15));
      r_rden   = 1'($urandom_range(0, 1));
      r_waddr  = 3'($urandom_range(0, 7));
      r_raddr  = 3'($urandom_range(0, 7));
      r_din    = $urandom;
      reset    = ($urandom_range(0, 15) == 0);
      #1;
      n_cmp++;
      if (f_dout !== ref_f[f_raddr]) begin
        n_bad++;
        $display("FAIL rand_fast[%0d]: got %h want %h", n, f_dout, ref_f[f_raddr]);
      end
      if (reset)       exp_r = 32'h0;
      else if (r_rden) exp_r = ref_r[r_raddr];
      if (f_wren && f_byteen[0]) ref_f[f_waddr] = f_din;
      if (r_wren) ref_r[r_waddr] = merge_lanes(ref_r[r_waddr], r_din, r_byteen);
      tick();
      n_cmp++;
      if (r_dout !== exp_r) begin
        n_bad++;
        $display("FAIL rand_reg[%0d]: got %h want %h", n, r_dout, exp_r);
      end
    end
    f_wren = 1'b0; r_wren = 1'b0; r_rden = 1'b0; reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    f_waddr  = '0; f_raddr = '0; f_wren = 1'b0; f_rden = 1'b0; f_byteen = '0; f_din = '0;
    r_waddr  = '0; r_raddr = '0; r_wren = 1'b0; r_rden = 1'b0; r_byteen = '0; r_din = '0;
    #2;
    test_reset();
    test_fast_read();
    test_fast_rdw();
    test_fast_byteen0();
    test_reg_byteen();
    test_reg_hold();
    test_reg_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
